tapped_shift_buffer: RTL and testbench

Parametrised successor of the 64-stage addressable shift register. It is a DEPTH-stage shift line with two independent random-access read taps and per-stage valid tracking. It also has a fill counter, a rotate (circular) mode and a synchronous clear. It sits in the datapath as the sample-history / delay-line store feeding window-based compute units, which read two taps per cycle.

---
 rtl/tapped_shift_buffer.sv | 95 +++++++++
 tb/tb_tapped_shift_buffer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/tapped_shift_buffer.sv
// DEPTH-stage shift line with two combinational random-access taps, per-stage
// valid bits, a fill counter, a circular (rotate) mode and a synchronous clear.
module tapped_shift_buffer #(
  parameter int unsigned dataWidth = 16,
  parameter int unsigned depth     = 64,
  parameter int unsigned addrWidth = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift,
  input  logic                 rotate,
  input  logic                 clear,
  input  logic [dataWidth-1:0] din,
  input  logic [addrWidth-1:0] addrA,
  input  logic [addrWidth-1:0] addrB,
  output logic [dataWidth-1:0] doutA,
  output logic [dataWidth-1:0] doutB,
  output logic                 validA,
  output logic                 validB,
  output logic [addrWidth:0]   count,
  output logic                 full
);

  localparam logic [addrWidth:0] DepthL = (addrWidth+1)'(depth);

  logic [dataWidth-1:0] stage_q [depth];
  logic [dataWidth-1:0] stage_d [depth];
  logic [depth-1:0]     valid_q, valid_d;
  logic [addrWidth:0]   count_q, count_d;
  logic                 v_in;

  always_comb begin
    stage_d = stage_q;
    valid_d = valid_q;
    count_d = count_q;
    v_in    = 1'b0;
    if (clear) begin
      for (int unsigned i = 0; i < depth; i++) begin
        stage_d[i] = '0;
      end
      valid_d = '0;
      count_d = '0;
    end else if (shift) begin
      for (int unsigned k = 1; k < depth; k++) begin
        stage_d[k] = stage_q[k-1];
      end
      if (rotate) begin
        stage_d[0] = stage_q[depth-1];
        v_in       = valid_q[depth-1];
      end else begin
        stage_d[0] = din;
        v_in       = 1'b1;
      end
      valid_d = {valid_q[depth-2:0], v_in};
      // count moves only when a new valid word enters and an empty stage leaves
      if (v_in && !valid_q[depth-1]) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < depth; i++) begin
        stage_q[i] <= '0;
      end
      valid_q <= '0;
      count_q <= '0;
    end else begin
      stage_q <= stage_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Out-of-range taps (non power-of-two depth) read as empty rather than aliasing
  always_comb begin
    doutA  = '0;
    validA = 1'b0;
    doutB  = '0;
    validB = 1'b0;
    if ({1'b0, addrA} < DepthL) begin
      doutA  = stage_q[addrA];
      validA = valid_q[addrA];
    end
    if ({1'b0, addrB} < DepthL) begin
      doutB  = stage_q[addrB];
      validB = valid_q[addrB];
    end
  end

  assign count = count_q;
  assign full  = (count_q == DepthL);

endmodule

// File: tb/tb_tapped_shift_buffer.sv
// Randomised + directed bench for tapped_shift_buffer; a queue-based history
// model per instance is checked against the DUT every cycle.
module tb_tapped_shift_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance (depth 64)
  logic        sh_b = 0, rot_b = 0, clr_b = 0;
  logic [15:0] din_b = '0;
  logic [5:0]  aA_b = '0, aB_b = '0;
  logic [15:0] doA_b, doB_b;
  logic        vA_b, vB_b, full_b;
  logic [6:0]  cnt_b;

  // small instance (depth 5, 3-bit taps)
  logic        sh_s = 0, rot_s = 0, clr_s = 0;
  logic [15:0] din_s = '0;
  logic [2:0]  aA_s = '0, aB_s = '0;
  logic [15:0] doA_s, doB_s;
  logic        vA_s, vB_s, full_s;
  logic [3:0]  cnt_s;

  tapped_shift_buffer #(.dataWidth(16), .depth(64), .addrWidth(6)) dut_b (
    .clk(clk), .rst(rst), .shift(sh_b), .rotate(rot_b), .clear(clr_b), .din(din_b),
    .addrA(aA_b), .addrB(aB_b), .doutA(doA_b), .doutB(doB_b),
    .validA(vA_b), .validB(vB_b), .count(cnt_b), .full(full_b));

  tapped_shift_buffer #(.dataWidth(16), .depth(5), .addrWidth(3)) dut_s (
    .clk(clk), .rst(rst), .shift(sh_s), .rotate(rot_s), .clear(clr_s), .din(din_s),
    .addrA(aA_s), .addrB(aB_s), .doutA(doA_s), .doutB(doB_s),
    .validA(vA_s), .validB(vB_s), .count(cnt_s), .full(full_s));

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Model: history list, element 0 = newest. A shift pushes at the front and
  // drops the oldest; a rotate moves the oldest entry to the front.
  typedef struct packed { logic [15:0] d; logic v; } ent_t;
  ent_t qb[$];
  ent_t qs[$];
  ent_t eb, es;
  bit   model_ok = 0;

  always @(posedge clk) begin
    if (rst) model_ok = 1;
    if (rst || clr_b) begin
      qb.delete();
      repeat (64) qb.push_back('0);
    end else if (sh_b && model_ok) begin
      eb = qb.pop_back();
      if (!rot_b) eb = {din_b, 1'b1};
      qb.push_front(eb);
    end
    if (rst || clr_s) begin
      qs.delete();
      repeat (5) qs.push_back('0);
    end else if (sh_s && model_ok) begin
      es = qs.pop_back();
      if (!rot_s) es = {din_s, 1'b1};
      qs.push_front(es);
    end
  end

  function automatic ent_t tap(input ent_t q[$], input int unsigned a);
    if (a < q.size()) return q[a];
    return '0;
  endfunction

  function automatic int unsigned pop(input ent_t q[$]);
    int unsigned c = 0;
    foreach (q[i]) c += q[i].v;
    return c;
  endfunction

  always @(negedge clk) begin
    if (model_ok) begin
      ent_t ta, tb;
      int unsigned c;
      ta = tap(qb, aA_b); tb = tap(qb, aB_b); c = pop(qb);
      chk("b_doutA", doA_b, ta.d);  chk("b_validA", vA_b, ta.v);
      chk("b_doutB", doB_b, tb.d);  chk("b_validB", vB_b, tb.v);
      chk("b_count", cnt_b, c);     chk("b_full", full_b, c == 64);
      ta = tap(qs, aA_s); tb = tap(qs, aB_s); c = pop(qs);
      chk("s_doutA", doA_s, ta.d);  chk("s_validA", vA_s, ta.v);
      chk("s_doutB", doB_s, tb.d);  chk("s_validB", vB_s, tb.v);
      chk("s_count", cnt_s, c);     chk("s_full", full_s, c == 5);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    // reset and idle
    rst = 1; step(); step(); rst = 0;
    repeat (10) step();
    aA_b = 0; aB_b = 63; #1;
    chk("idle_doutA", doA_b, 0); chk("idle_doutB", doB_b, 0);
    chk("idle_validA", vA_b, 0); chk("idle_count", cnt_b, 0); chk("idle_full", full_b, 0);

    // fill 1..70
    for (int i = 1; i <= 70; i++) begin
      sh_b = 1; din_b = 16'(i); step();
      if (i == 5) begin
        aA_b = 0; aB_b = 4; #1;
        chk("fill5_tap0", doA_b, 5); chk("fill5_tap4", doB_b, 1); chk("fill5_v4", vB_b, 1);
        aA_b = 5; #1;
        chk("fill5_v5", vA_b, 0);
      end
    end
    sh_b = 0; aA_b = 0; aB_b = 63; #1;
    chk("fill70_count", cnt_b, 64); chk("fill70_full", full_b, 1);
    chk("fill70_tap63", doB_b, 7);  chk("fill70_tap0", doA_b, 70);

    // 64 rotations must restore the line and never admit din
    for (int i = 0; i < 64; i++) begin
      sh_b = 1; rot_b = 1; din_b = 16'hFFFF; aA_b = 6'($urandom_range(0, 63));
      step();
      chk("rot_count", cnt_b, 64);
      chk("rot_no_din", doA_b == 16'hFFFF, 0);
    end
    sh_b = 0; rot_b = 0; aA_b = 0; aB_b = 63; #1;
    chk("rot_tap0", doA_b, 70); chk("rot_tap63", doB_b, 7);

    // clear beats shift
    clr_b = 1; step(); clr_b = 0;
    for (int i = 0; i < 40; i++) begin sh_b = 1; din_b = 16'($urandom); step(); end
    sh_b = 0; #1;
    chk("pre_clear_count", cnt_b, 40);
    clr_b = 1; sh_b = 1; din_b = 16'h1234; step();
    clr_b = 0; sh_b = 0; aA_b = 0; #1;
    chk("clr_count", cnt_b, 0); chk("clr_tap0", doA_b, 0); chk("clr_validA", vA_b, 0);
    sh_b = 1; din_b = 16'h1234; step(); sh_b = 0; #1;
    chk("post_clr_count", cnt_b, 1); chk("post_clr_tap0", doA_b, 16'h1234);

    // reset during a shift stream
    clr_b = 1; step(); clr_b = 0;
    for (int i = 0; i < 12; i++) begin sh_b = 1; din_b = 16'(100 + i); step(); end
    #1; chk("pre_rst_count", cnt_b, 12);
    rst = 1; step(); rst = 0; aA_b = 0; aB_b = 5; #1;
    chk("rst_count", cnt_b, 0); chk("rst_tap0", doA_b, 0); chk("rst_tap5", doB_b, 0);
    din_b = 16'd500; step(); sh_b = 0; #1;
    chk("rst_refill_count", cnt_b, 1); chk("rst_refill_tap0", doA_b, 500);

    // depth-5 partial rotate and out-of-range tap
    clr_s = 1; step(); clr_s = 0;
    sh_s = 1;
    din_s = 10; step(); din_s = 20; step(); din_s = 30; step();
    rot_s = 1; din_s = 16'hFFFF; step();
    sh_s = 0; rot_s = 0; aA_s = 0; aB_s = 1; #1;
    chk("s_rot_tap0", doA_s, 0); chk("s_rot_v0", vA_s, 0);
    chk("s_rot_tap1", doB_s, 30); chk("s_rot_count", cnt_s, 3);
    aA_s = 6; #1;
    chk("s_oor_dout", doA_s, 0); chk("s_oor_valid", vA_s, 0);

    // random traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 399) == 0);
      sh_b  = ($urandom_range(0, 3) != 0);
      rot_b = ($urandom_range(0, 3) == 0);
      clr_b = ($urandom_range(0, 149) == 0);
      din_b = 16'($urandom);
      aA_b  = 6'($urandom_range(0, 63));
      aB_b  = 6'($urandom_range(0, 63));
      sh_s  = ($urandom_range(0, 2) != 0);
      rot_s = ($urandom_range(0, 2) == 0);
      clr_s = ($urandom_range(0, 49) == 0);
      din_s = 16'($urandom);
      aA_s  = 3'($urandom_range(0, 7));
      aB_s  = 3'($urandom_range(0, 7));
      step();
    end
    rst = 0; sh_b = 0; sh_s = 0; clr_b = 0; clr_s = 0;
    step(); @(negedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
